// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT/MULTU/DIV/DIVU write HI/LO at edge W+1 after the start edge; MTHI/MTLO write at the start edge.
// Backpressure: busy=1 during RUN/FIXUP; start is ignored while busy, flush squashes any in-flight op.
// Ports: clk/rst_n (async active-low), op1/op2 operands, mdu_op/start request, flush squash,
//        busy/done status, hi/lo architectural results.
// Optional feature: define MDU_FAST_MUL_EN for a single-cycle multiplier that bypasses RUN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mdu_ctrl #(
    parameter int W = `WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic [2:0]   mdu_op,
    input  logic         start,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_hi_q, acc_hi_d;   // multiply: product high half; divide: partial remainder
    logic [W-1:0]  acc_lo_q, acc_lo_d;   // multiply: product low half/multiplier; divide: quotient
    logic [W-1:0]  b_q, b_d;             // multiplicand or divisor magnitude
    logic [W-1:0]  a_raw_q, a_raw_d;     // unmodified op1, returned as HI on divide-by-zero
    logic          is_div_q, is_div_d;
    logic          neg_q, neg_d;         // negate product / quotient
    logic          rneg_q, rneg_d;       // negate remainder (dividend was negative)
    logic          div0_q, div0_d;
    logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic          done_q, done_d;

    logic          is_mul, is_div, is_sgn;
    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    mul_sum, div_r, div_diff;
    logic [2*W-1:0] prod, prod_fix;

`ifdef MDU_FAST_MUL_EN
    logic fmul_q, fmul_d;                // fast product pending for the next edge
    logic sgn_q, sgn_d;
    logic signed [2*W+1:0] fast_full;
    logic [2*W-1:0]        fast_prod;
    assign fast_full = $signed({sgn_q & a_raw_q[W-1], a_raw_q}) * $signed({sgn_q & b_q[W-1], b_q});
    assign fast_prod = fast_full[2*W-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_d      = b_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MDU_FAST_MUL_EN
        fmul_d   = 1'b0;
        sgn_d    = sgn_q;
`endif
        is_mul   = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        is_div   = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
        is_sgn   = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
        a_mag    = (is_sgn && op1[W-1]) ? -op1 : op1;
        b_mag    = (is_sgn && op2[W-1]) ? -op2 : op2;
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        div_r    = {acc_hi_q, acc_lo_q[W-1]};
        div_diff = div_r - {1'b0, b_q};
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? -prod : prod;

        unique case (state_q)
            S_IDLE: begin
                if (!flush) begin
`ifdef MDU_FAST_MUL_EN
                    if (fmul_q) begin
                        {hi_d, lo_d} = fast_prod;
                        done_d       = 1'b1;
                    end
`endif
                    // A move issued right behind a fast multiply is younger, so it overrides.
                    if (start) begin
                        if (mdu_op == OP_MTHI) begin
                            hi_d = op1;
                        end else if (mdu_op == OP_MTLO) begin
                            lo_d = op1;
`ifdef MDU_FAST_MUL_EN
                        end else if (is_mul) begin
                            fmul_d  = 1'b1;
                            sgn_d   = is_sgn;
                            a_raw_d = op1;
                            b_d     = op2;
`endif
                        end else if (is_mul || is_div) begin
                            state_d  = S_RUN;
                            cnt_d    = '0;
                            acc_hi_d = '0;
                            acc_lo_d = is_div ? a_mag : b_mag;
                            b_d      = is_div ? b_mag : a_mag;
                            a_raw_d  = op1;
                            is_div_d = is_div;
                            neg_d    = is_sgn && (op1[W-1] ^ op2[W-1]);
                            rneg_d   = is_sgn && op1[W-1];
                            div0_d   = is_div && (op2 == '0);
                        end
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        // Restoring step: bit W of the difference is the borrow.
                        if (!div_diff[W]) begin
                            acc_hi_d = div_diff[W-1:0];
                            acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
                        end else begin
                            acc_hi_d = div_r[W-1:0];
                            acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[W-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = S_FIXUP;
                    end
                end
            end
            S_FIXUP: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (div0_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                        lo_d = neg_q  ? -acc_lo_q : acc_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_q      <= b_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

`ifdef MDU_FAST_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmul_q <= 1'b0;
            sgn_q  <= 1'b0;
        end else begin
            fmul_q <= fmul_d;
            sgn_q  <= sgn_d;
        end
    end
`endif

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  op1, op2, hi, lo;
    logic [2:0]    mdu_op;
    logic          start, flush, busy, done;
    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  m_hi, m_lo;

    mdu_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .op1(op1), .op2(op2), .mdu_op(mdu_op),
        .start(start), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Architectural result {hi,lo} straight from the instruction semantics.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        if ((op == 3'd3 || op == 3'd4) && b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else if (op == 3'd1) begin
            p = sa * sb;
        end else if (op == 3'd2) begin
            p = {32'd0, a} * {32'd0, b};
        end else if (op == 3'd3) begin
            q = sa / sb;
            r = sa % sb;
            qv = q;
            rv = r;
            p = {rv[31:0], qv[31:0]};
        end else if (op == 3'd4) begin
            p = {({32'd0, a} % {32'd0, b}) , 32'd0} | ({32'd0, a} / {32'd0, b});
        end
        return p;
    endfunction

    // Issue one accepted arithmetic op, wait for done, check latency and result.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] e;
        bit          fast;
        int          n;
        int          lat;
        fast = FAST && (op == 3'd1 || op == 3'd2);
        // Number of rising edges from the start edge through the result edge, inclusive.
        lat  = fast ? 2 : W + 2;
        e    = model(op, a, b);
        mdu_op = op; op1 = a; op2 = b; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        chk({tag, "_busy"}, 64'(busy), 64'(!fast));
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
        m_hi = e[63:32];
        m_lo = e[31:0];
        step();
        chk({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a, input string tag);
        mdu_op = op; op1 = a; start = 1'b1;
        step();
        start = 1'b0;
        if (op == 3'd5) m_hi = a; else m_lo = a;
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
        chk({tag, "_st"}, {62'd0, done, busy}, 64'd0);
    endtask

    task automatic nop(input logic [2:0] op, input string tag);
        mdu_op = op; op1 = $urandom; op2 = $urandom; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_st"}, {62'd0, done, busy}, 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int n;
        int k;
        int dn;
        logic [2:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; mdu_op = 3'd0; op1 = '0; op2 = '0;
        m_hi = '0; m_lo = '0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        step();

        // Directed corner cases
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, "mult_m1x2");
        chk("mult_m1x2_hiabs", 64'(hi), 64'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, "multu_x2");
        chk("multu_x2_hiabs", 64'(hi), 64'h1);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        chk("div_m7_2_loabs", 64'(lo), 64'hFFFF_FFFD);
        do_op(3'd4, 32'd100, 32'd0, "divu_by0");
        chk("divu_by0_hiabs", 64'(hi), 64'd100);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf_loabs", 64'(lo), 64'h8000_0000);
        do_op(3'd3, 32'hFFFF_FF00, 32'd0, "div_by0");
        do_op(3'd3, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mult_min");
        nop(3'd0, "none0");
        nop(3'd7, "none7");

        // MTHI then DIVU flushed on its 10th cycle
        mt(3'd5, 32'h1234_5678, "mthi");
        mdu_op = 3'd4; op1 = 32'd7; op2 = 32'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_run_busy", 64'(busy), 64'd0);
        dn = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done) dn++;
            step();
        end
        chk("flush_run_nodone", 64'(dn), 64'd0);
        chk("flush_run_hi", 64'(hi), 64'h1234_5678);
        chk("flush_run_lo", 64'(lo), 64'(m_lo));

        // Flush on the FIXUP edge suppresses the write
        mdu_op = 3'd4; op1 = 32'd50; op2 = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (W) step();
        chk("fixup_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_fix_st", {62'd0, done, busy}, 64'd0);
        repeat (3) step();
        chk("flush_fix_done", 64'(done), 64'd0);
        chk("flush_fix_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush concurrent with start in IDLE discards the request
        mdu_op = 3'd6; op1 = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        step();
        mdu_op = 3'd4; op1 = 32'd9;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_st", {62'd0, done, busy}, 64'd0);
        chk("flush_idle_hilo", {hi, lo}, {m_hi, m_lo});

        // Reset pulse mid-RUN
        mdu_op = 3'd4; op1 = 32'd7; op2 = 32'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {busy, done, hi, lo}, 66'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_op(3'd4, 32'd9, 32'd4, "divu_9_4");

        // Start held high through a busy op: operand changes while busy must be ignored
        mdu_op = 3'd4; op1 = 32'd7; op2 = 32'd2; start = 1'b1;
        step();
        op1 = 32'd9; op2 = 32'd4;
        n = 1;
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk("hold_lat", 64'(n), 64'(W + 2));
        chk("hold_res1", {hi, lo}, {32'd1, 32'd3});
        k = 0;
        while (!busy && k < 4) begin
            step();
            k++;
        end
        start = 1'b0;
        chk("hold_accept2", 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk("hold_res2", {hi, lo}, {32'd1, 32'd2});
        m_hi = 32'd1; m_lo = 32'd2;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done || busy) dn++;
        end
        chk("hold_quiet", 64'(dn), 64'd0);

        // Randomized mix against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'(-int'($urandom_range(1, 15)));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if (op >= 3'd1 && op <= 3'd4)      do_op(op, a, b, "rnd_op");
            else if (op == 3'd5 || op == 3'd6) mt(op, a, "rnd_mt");
            else                               nop(op, "rnd_none");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
